// File: rtl/register_file_arbiter_pkg.sv
// register_file_pkg: shared types and constants for the register-file arbiter.
//   DATA_WIDTH                  - register-file word width
//   DEFAULT_NUMBER_OF_REGISTERS - default register-file depth
//   MAX_ADDRESS_WIDTH           - address width carried in rf_request_t; narrower
//                                 addresses are zero-extended into it
//   rf_request_t                - one captured request {write, address, data}
//   lock_state_t                - arbitration lock FSM states
package register_file_pkg;
    localparam int DATA_WIDTH                  = 8;
    localparam int DEFAULT_NUMBER_OF_REGISTERS = 256;
    localparam int MAX_ADDRESS_WIDTH           = 16;

    typedef struct packed {
        logic                         write;
        logic [MAX_ADDRESS_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0]        data;
    } rf_request_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;
endpackage

// File: rtl/register_file_arbiter_if.sv
// register_file_arbiter_if: requester bus and register-file port bundle.
//   request_*      - per-requester valid/write/lock/address/data, packed per requester
//   request_ready_out, response_valid_out (one-hot), response_data_out (shared)
//   rf_*           - single write port and read port 1 of the register file
// Modports: slave = arbiter side, master = requesters + register file side.
interface register_file_arbiter_if #(
    parameter int NUMBER_OF_REQUESTERS = 4,
    parameter int ADDRESS_WIDTH        = 8
);
    import register_file_pkg::*;

    logic [NUMBER_OF_REQUESTERS-1:0]               request_valid_in;
    logic [NUMBER_OF_REQUESTERS-1:0]               request_write_in;
    logic [NUMBER_OF_REQUESTERS-1:0]               request_lock_in;
    logic [NUMBER_OF_REQUESTERS*ADDRESS_WIDTH-1:0] request_address_in;
    logic [NUMBER_OF_REQUESTERS*DATA_WIDTH-1:0]    request_data_in;
    logic [NUMBER_OF_REQUESTERS-1:0]               request_ready_out;
    logic [NUMBER_OF_REQUESTERS-1:0]               response_valid_out;
    logic [DATA_WIDTH-1:0]                         response_data_out;
    logic                                          rf_write_enable_out;
    logic [ADDRESS_WIDTH-1:0]                      rf_write_address_out;
    logic [DATA_WIDTH-1:0]                         rf_write_data_out;
    logic [ADDRESS_WIDTH-1:0]                      rf_read_address_out;
    logic [DATA_WIDTH-1:0]                         rf_read_data_in;

    modport slave (
        input  request_valid_in, request_write_in, request_lock_in,
        input  request_address_in, request_data_in, rf_read_data_in,
        output request_ready_out, response_valid_out, response_data_out,
        output rf_write_enable_out, rf_write_address_out, rf_write_data_out,
        output rf_read_address_out
    );

    modport master (
        output request_valid_in, request_write_in, request_lock_in,
        output request_address_in, request_data_in, rf_read_data_in,
        input  request_ready_out, response_valid_out, response_data_out,
        input  rf_write_enable_out, rf_write_address_out, rf_write_data_out,
        input  rf_read_address_out
    );
endinterface

// File: rtl/register_file_arbiter_round_robin.sv
// round_robin_arbiter: combinational one-hot grant.
//   request_i     - valid requests
//   pointer_i     - highest-priority requester this cycle
//   lock_enable_i - when set only lock_owner_i may be granted
//   lock_owner_i  - requester holding the lock
//   grant_o       - one-hot grant, zero when nothing eligible
module round_robin_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         request_i,
    input  logic [$clog2(N)-1:0] pointer_i,
    input  logic                 lock_enable_i,
    input  logic [$clog2(N)-1:0] lock_owner_i,
    output logic [N-1:0]         grant_o
);
    localparam int PW = $clog2(N);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        if (lock_enable_i) begin
            // Owner idle while locked: nobody else gets in.
            grant_o[lock_owner_i] = request_i[lock_owner_i];
        end else begin
            // Scan upward from the pointer with wrap; first valid wins.
            for (int k = 0; k < N; k++) begin
                idx = PW'((int'(pointer_i) + k) % N);
                if (!found && request_i[idx]) begin
                    grant_o[idx] = 1'b1;
                    found        = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/register_file_arbiter.sv
// register_file_arbiter: shares the register-file write port and read port 1
// between NUMBER_OF_REQUESTERS requesters, round-robin with optional lock.
//   clock_in, reset_n_in - clock, async active-low reset
//   bus (slave)          - requester handshake, responses and register-file ports
// Accept in T -> issue on rf ports in T+1 -> read response in T+2.
module register_file_arbiter
    import register_file_pkg::*;
#(
    parameter int NUMBER_OF_REQUESTERS = 4,
    parameter int NUMBER_OF_REGISTERS  = DEFAULT_NUMBER_OF_REGISTERS
) (
    input logic                    clock_in,
    input logic                    reset_n_in,
    register_file_arbiter_if.slave bus
);
    localparam int N  = NUMBER_OF_REQUESTERS;
    localparam int AW = $clog2(NUMBER_OF_REGISTERS);
    localparam int PW = $clog2(N);

    logic [PW-1:0] pointer_q, pointer_d;
    logic [PW-1:0] lock_owner_q, lock_owner_d;
    lock_state_t   lock_state_q, lock_state_d;

    logic [N-1:0]  grant, accept;
    logic          accept_any;
    logic [PW-1:0] grant_idx;
    rf_request_t   acc_req;

    logic          iss_valid_q;
    rf_request_t   iss_q;
    logic [PW-1:0] iss_owner_q;
    logic          issue_write, issue_read;

    logic [AW-1:0]         wr_addr, wr_addr_hold_q;
    logic [DATA_WIDTH-1:0] wr_data, wr_data_hold_q;
    logic [AW-1:0]         rd_addr, rd_addr_hold_q;
    logic [N-1:0]          resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_data_q;

    round_robin_arbiter #(.N(N)) u_arb (
        .request_i     (bus.request_valid_in),
        .pointer_i     (pointer_q),
        .lock_enable_i (lock_state_q == LOCKED),
        .lock_owner_i  (lock_owner_q),
        .grant_o       (grant)
    );

    // Ready must read zero while reset is held, even with requests pending.
    assign accept                = grant & {N{reset_n_in}};
    assign accept_any            = |accept;
    assign bus.request_ready_out = accept;

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (accept[k]) grant_idx = PW'(k);
        end
        acc_req.write   = bus.request_write_in[grant_idx];
        acc_req.address = MAX_ADDRESS_WIDTH'(bus.request_address_in[grant_idx*AW +: AW]);
        acc_req.data    = bus.request_data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end

    // Pointer / lock FSM next state.
    always_comb begin
        pointer_d    = pointer_q;
        lock_owner_d = lock_owner_q;
        lock_state_d = lock_state_q;
        if (accept_any) begin
            pointer_d    = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
            lock_owner_d = grant_idx;
            // Only the owner can be accepted while locked, so its lock bit alone
            // decides whether the lock is taken, kept or released.
            lock_state_d = bus.request_lock_in[grant_idx] ? LOCKED : UNLOCKED;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            pointer_q    <= '0;
            lock_owner_q <= '0;
            lock_state_q <= UNLOCKED;
        end else begin
            pointer_q    <= pointer_d;
            lock_owner_q <= lock_owner_d;
            lock_state_q <= lock_state_d;
        end
    end

    assign issue_write = iss_valid_q &  iss_q.write;
    assign issue_read  = iss_valid_q & ~iss_q.write;

    // rf ports show the issuing request, otherwise hold their last value.
    assign wr_addr = issue_write ? AW'(iss_q.address) : wr_addr_hold_q;
    assign wr_data = issue_write ? iss_q.data         : wr_data_hold_q;
    assign rd_addr = issue_read  ? AW'(iss_q.address) : rd_addr_hold_q;

    assign bus.rf_write_enable_out  = issue_write;
    assign bus.rf_write_address_out = wr_addr;
    assign bus.rf_write_data_out    = wr_data;
    assign bus.rf_read_address_out  = rd_addr;
    assign bus.response_valid_out   = resp_valid_q;
    assign bus.response_data_out    = resp_data_q;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            iss_valid_q    <= 1'b0;
            iss_q          <= '0;
            iss_owner_q    <= '0;
            wr_addr_hold_q <= '0;
            wr_data_hold_q <= '0;
            rd_addr_hold_q <= '0;
            resp_valid_q   <= '0;
            resp_data_q    <= '0;
        end else begin
            iss_valid_q    <= accept_any;
            if (accept_any) begin
                iss_q       <= acc_req;
                iss_owner_q <= grant_idx;
            end
            wr_addr_hold_q <= wr_addr;
            wr_data_hold_q <= wr_data;
            rd_addr_hold_q <= rd_addr;
            resp_valid_q   <= issue_read ? ({{(N-1){1'b0}}, 1'b1} << iss_owner_q) : '0;
            if (issue_read) resp_data_q <= bus.rf_read_data_in;
        end
    end
endmodule

// File: tb/tb_register_file_arbiter.sv
module tb_register_file_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    register_file_arbiter_if #(.NUMBER_OF_REQUESTERS(N), .ADDRESS_WIDTH(AW)) bus ();

    register_file_arbiter #(.NUMBER_OF_REQUESTERS(N), .NUMBER_OF_REGISTERS(256)) dut (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .bus        (bus)
    );

    // Register file model: synchronous write, combinational read.
    logic [7:0] mem [256];
    always @(posedge clk) if (bus.rf_write_enable_out) mem[bus.rf_write_address_out] <= bus.rf_write_data_out;
    assign bus.rf_read_data_in = mem[bus.rf_read_address_out];

    int checks = 0;
    int passed = 0;

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic clear_reqs();
        bus.request_valid_in   = '0;
        bus.request_write_in   = '0;
        bus.request_lock_in    = '0;
        bus.request_address_in = '0;
        bus.request_data_in    = '0;
    endtask

    task automatic set_req(input int i, input logic w, input logic lk, input logic [7:0] a, input logic [7:0] d);
        bus.request_valid_in[i]          = 1'b1;
        bus.request_write_in[i]          = w;
        bus.request_lock_in[i]           = lk;
        bus.request_address_in[i*AW +: AW] = a;
        bus.request_data_in[i*8 +: 8]    = d;
    endtask

    task automatic drop(input int i);
        bus.request_valid_in[i] = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_reqs();
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 8'h33, 8'h44);
        cyc(); cyc();
        checks++; if (bus.request_ready_out !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", bus.request_ready_out); else passed++;
        checks++; if (bus.response_valid_out !== 4'b0000) $display("FAIL reset_resp_valid: got %b expected 0000", bus.response_valid_out); else passed++;
        checks++; if (bus.rf_write_enable_out !== 1'b0) $display("FAIL reset_we: got %b expected 0", bus.rf_write_enable_out); else passed++;
        checks++; if (bus.rf_write_address_out !== 8'h00) $display("FAIL reset_waddr: got %h expected 00", bus.rf_write_address_out); else passed++;
        checks++; if (bus.rf_write_data_out !== 8'h00) $display("FAIL reset_wdata: got %h expected 00", bus.rf_write_data_out); else passed++;
        checks++; if (bus.rf_read_address_out !== 8'h00) $display("FAIL reset_raddr: got %h expected 00", bus.rf_read_address_out); else passed++;
        checks++; if (bus.response_data_out !== 8'h00) $display("FAIL reset_resp_data: got %h expected 00", bus.response_data_out); else passed++;
        clear_reqs();
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        set_req(1, 1'b1, 1'b0, 8'h10, 8'hA5); #1;
        checks++; if (bus.request_ready_out !== 4'b0010) $display("FAIL wr_ready: got %b expected 0010", bus.request_ready_out); else passed++;
        cyc();
        checks++; if (bus.rf_write_enable_out !== 1'b1) $display("FAIL wr_we: got %b expected 1", bus.rf_write_enable_out); else passed++;
        checks++; if (bus.rf_write_address_out !== 8'h10) $display("FAIL wr_waddr: got %h expected 10", bus.rf_write_address_out); else passed++;
        checks++; if (bus.rf_write_data_out !== 8'hA5) $display("FAIL wr_wdata: got %h expected a5", bus.rf_write_data_out); else passed++;
        set_req(1, 1'b0, 1'b0, 8'h10, 8'h00); #1;
        checks++; if (bus.request_ready_out !== 4'b0010) $display("FAIL rd_ready: got %b expected 0010", bus.request_ready_out); else passed++;
        cyc(); drop(1);
        checks++; if (bus.rf_write_enable_out !== 1'b0) $display("FAIL wr_we_one_cycle: got %b expected 0", bus.rf_write_enable_out); else passed++;
        checks++; if (bus.rf_read_address_out !== 8'h10) $display("FAIL rd_raddr: got %h expected 10", bus.rf_read_address_out); else passed++;
        checks++; if (bus.response_valid_out !== 4'b0000) $display("FAIL rd_resp_early: got %b expected 0000", bus.response_valid_out); else passed++;
        cyc();
        checks++; if (bus.response_valid_out !== 4'b0010) $display("FAIL rd_resp_valid: got %b expected 0010", bus.response_valid_out); else passed++;
        checks++; if (bus.response_data_out !== 8'hA5) $display("FAIL rd_resp_data: got %h expected a5", bus.response_data_out); else passed++;
        cyc();
        checks++; if (bus.response_valid_out !== 4'b0000) $display("FAIL rd_resp_pulse: got %b expected 0000", bus.response_valid_out); else passed++;
        checks++; if (bus.response_data_out !== 8'hA5) $display("FAIL rd_resp_hold: got %h expected a5", bus.response_data_out); else passed++;
    endtask

    task automatic test_back_to_back();
        set_req(0, 1'b1, 1'b0, 8'h05, 8'h7E); #1;
        checks++; if (bus.request_ready_out !== 4'b0001) $display("FAIL b2b_wr_ready: got %b expected 0001", bus.request_ready_out); else passed++;
        cyc();
        set_req(0, 1'b0, 1'b0, 8'h05, 8'h00); #1;
        checks++; if (bus.request_ready_out !== 4'b0001) $display("FAIL b2b_rd_ready: got %b expected 0001", bus.request_ready_out); else passed++;
        cyc(); drop(0);
        cyc();
        checks++; if (bus.response_valid_out !== 4'b0001) $display("FAIL b2b_resp_valid: got %b expected 0001", bus.response_valid_out); else passed++;
        checks++; if (bus.response_data_out !== 8'h7E) $display("FAIL b2b_resp_data: got %h expected 7e", bus.response_data_out); else passed++;
        cyc();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        apply_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 8'(i), 8'h00);
        for (int k = 0; k < 8; k++) begin
            exp = 4'b0001 << (k % 4);
            #1;
            checks++; if (bus.request_ready_out !== exp) $display("FAIL rr_grant%0d: got %b expected %b", k, bus.request_ready_out, exp); else passed++;
            cyc();
        end
        clear_reqs();
        cyc(); cyc();
    endtask

    task automatic test_lock();
        apply_reset();
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00); #1;
        checks++; if (bus.request_ready_out !== 4'b0010) $display("FAIL lk_prime: got %b expected 0010", bus.request_ready_out); else passed++;
        cyc(); drop(1);
        set_req(0, 1'b0, 1'b0, 8'h40, 8'h00);
        set_req(3, 1'b0, 1'b0, 8'h41, 8'h00);
        for (int j = 0; j < 3; j++) begin
            set_req(2, 1'b1, 1'b1, 8'(8'h20 + j), 8'(j + 1)); #1;
            checks++; if (bus.request_ready_out !== 4'b0100) $display("FAIL lk_ready%0d: got %b expected 0100", j, bus.request_ready_out); else passed++;
            cyc();
            checks++; if (bus.rf_write_enable_out !== 1'b1 || bus.rf_write_address_out !== 8'(8'h20 + j))
                $display("FAIL lk_write%0d: got we=%b addr=%h expected we=1 addr=%h", j, bus.rf_write_enable_out, bus.rf_write_address_out, 8'(8'h20 + j));
            else passed++;
        end
        drop(2); #1;
        checks++; if (bus.request_ready_out !== 4'b0000) $display("FAIL lk_owner_idle: got %b expected 0000", bus.request_ready_out); else passed++;
        cyc();
        set_req(2, 1'b1, 1'b0, 8'h23, 8'h04); #1;
        checks++; if (bus.request_ready_out !== 4'b0100) $display("FAIL lk_unlock_ready: got %b expected 0100", bus.request_ready_out); else passed++;
        cyc(); drop(2); #1;
        checks++; if (bus.request_ready_out !== 4'b1000) $display("FAIL lk_next_grant: got %b expected 1000", bus.request_ready_out); else passed++;
        cyc(); #1;
        checks++; if (bus.request_ready_out !== 4'b0001) $display("FAIL lk_after_next: got %b expected 0001", bus.request_ready_out); else passed++;
        cyc();
        clear_reqs();
        cyc(); cyc(); cyc();
        for (int j = 0; j < 4; j++) begin
            checks++; if (mem[8'h20 + j] !== 8'(j + 1)) $display("FAIL lk_mem%0d: got %h expected %h", j, mem[8'h20 + j], 8'(j + 1)); else passed++;
        end
    endtask

    task automatic test_reset_mid_op();
        set_req(0, 1'b1, 1'b0, 8'h30, 8'h55); #1;
        cyc(); drop(0);
        cyc();
        set_req(2, 1'b1, 1'b0, 8'h30, 8'hFF); #1;
        checks++; if (bus.request_ready_out !== 4'b0100) $display("FAIL rm_ready: got %b expected 0100", bus.request_ready_out); else passed++;
        cyc(); drop(2);
        checks++; if (bus.rf_write_enable_out !== 1'b1) $display("FAIL rm_we_issue: got %b expected 1", bus.rf_write_enable_out); else passed++;
        rst_n = 1'b0; #1;
        checks++; if (bus.rf_write_enable_out !== 1'b0) $display("FAIL rm_we_drop: got %b expected 0", bus.rf_write_enable_out); else passed++;
        cyc(); cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++; if (bus.response_valid_out !== 4'b0000) $display("FAIL rm_stray_resp%0d: got %b expected 0000", k, bus.response_valid_out); else passed++;
        end
        set_req(3, 1'b0, 1'b0, 8'h30, 8'h00); #1;
        checks++; if (bus.request_ready_out !== 4'b1000) $display("FAIL rm_rd_ready: got %b expected 1000", bus.request_ready_out); else passed++;
        cyc(); drop(3);
        cyc();
        checks++; if (bus.response_valid_out !== 4'b1000) $display("FAIL rm_resp_valid: got %b expected 1000", bus.response_valid_out); else passed++;
        checks++; if (bus.response_data_out !== 8'h55) $display("FAIL rm_resp_data: got %h expected 55", bus.response_data_out); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        clear_reqs();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_round_robin();
        test_lock();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
